// File: rtl/mult_rr_sched.sv
// mult_rr_sched: one shift-add sequential multiplier shared by two requesters.
// Requests are arbitrated round-robin in IDLE. The winner's operands are captured,
// and WIDTH add/shift iterations run. The product is then published with the ID of
// the requester that was served.
module mult_rr_sched #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   p,
    output logic                 p_valid,
    output logic                 p_id
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [PW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_win_id;
    logic             r_last_id;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_busy;
    logic [PW-1:0]    r_p;
    logic             r_p_valid;
    logic             r_p_id;

    logic             w_any_req;
    logic             w_winner;
    logic [PW-1:0]    w_pp [WIDTH];
    logic [PW-1:0]    w_term;
    logic [PW-1:0]    w_sum;

    // A lone requester always wins. When both request, the one not served last time wins.
    assign w_any_req = req0 | req1;
    assign w_winner  = (req0 & req1) ? ~r_last_id : req1;

    // One partial product per multiplier bit. The counter selects the one added this iteration.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_pp
            assign w_pp[gi] = r_b[gi] ? (PW'(r_a) << gi) : '0;
        end
    endgenerate

    assign w_term = w_pp[r_cnt];
    assign w_sum  = r_acc + w_term;

    // Control FSM and datapath. Every output is a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_win_id  <= 1'b0;
            r_last_id <= 1'b1;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_busy    <= 1'b0;
            r_p       <= '0;
            r_p_valid <= 1'b0;
            r_p_id    <= 1'b0;
        end else begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_a       <= w_winner ? a1 : a0;
                        r_b       <= w_winner ? b1 : b0;
                        r_win_id  <= w_winner;
                        r_last_id <= w_winner;
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        r_gnt0    <= ~w_winner;
                        r_gnt1    <= w_winner;
                        r_busy    <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST_ITER) begin
                        r_p       <= w_sum;
                        r_p_id    <= r_win_id;
                        r_p_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_p_valid <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_p_valid <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt0    = r_gnt0;
    assign gnt1    = r_gnt1;
    assign busy    = r_busy;
    assign p       = r_p;
    assign p_valid = r_p_valid;
    assign p_id    = r_p_id;

endmodule

// File: tb/tb_mult_rr_sched.sv
// Testbench for mult_rr_sched. The stimulus pushes expected grants and products into
// queues, computed from the round-robin rule and plain multiplication. A monitor pops
// and compares them whenever the DUT raises a grant or p_valid.
module tb_mult_rr_sched;
    localparam int WIDTH = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req0 = 1'b0;
    logic               req1 = 1'b0;
    logic [WIDTH-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic               gnt0, gnt1, busy, p_valid, p_id;
    logic [2*WIDTH-1:0] p;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic id;
        int   prod;
    } exp_t;

    exp_t res_q[$];
    logic gnt_q[$];
    logic model_last = 1'b1;

    int   cyc       = 0;
    int   gnt_cyc   = -100;
    int   busy_run  = 0;
    logic prev_gnt  = 1'b0;
    logic prev_pv   = 1'b0;
    logic prev_busy = 1'b0;
    exp_t mon_e;
    logic mon_id;

    mult_rr_sched #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
        .p(p), .p_valid(p_valid), .p_id(p_id)
    );

    always #5 clk = ~clk;

    // Cycle counter, stepped on each active edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares grants and published products against the scoreboard queues.
    always @(negedge clk) begin
        if (rst) begin
            busy_run  = 0;
            prev_gnt  = 1'b0;
            prev_pv   = 1'b0;
            prev_busy = 1'b0;
        end else begin
            check("gnt_exclusive", {63'd0, gnt0 & gnt1}, 64'd0);
            if (gnt0 | gnt1) begin
                check("gnt_pulse_width", {63'd0, prev_gnt}, 64'd0);
                check("busy_at_gnt", {63'd0, busy}, 64'd1);
                if (gnt_q.size() == 0) begin
                    check("unexpected_gnt", 64'd1, 64'd0);
                end else begin
                    mon_id = gnt_q.pop_front();
                    check("gnt_id", {63'd0, gnt1}, {63'd0, mon_id});
                end
                gnt_cyc = cyc;
            end
            if (p_valid) begin
                check("p_valid_pulse", {63'd0, prev_pv}, 64'd0);
                check("gnt_to_p_valid", 64'(cyc - gnt_cyc), 64'(WIDTH));
                if (res_q.size() == 0) begin
                    check("unexpected_p_valid", 64'd1, 64'd0);
                end else begin
                    mon_e = res_q.pop_front();
                    check("p_id", {63'd0, p_id}, {63'd0, mon_e.id});
                    check("p", 64'(p), 64'(mon_e.prod));
                end
            end
            if (busy) begin
                busy_run++;
            end else if (prev_busy) begin
                check("busy_length", 64'(busy_run), 64'(WIDTH + 1));
                busy_run = 0;
            end
            prev_gnt  = gnt0 | gnt1;
            prev_pv   = p_valid;
            prev_busy = busy;
        end
    end

    // One arbitration round, entered at a negedge. mask bit0 = requester 0, bit1 = requester 1.
    // Each requester holds its request until granted and then scrambles its operands.
    task automatic do_round(input int mask, input logic [WIDTH-1:0] xa0, input logic [WIDTH-1:0] xb0,
                            input logic [WIDTH-1:0] xa1, input logic [WIDTH-1:0] xb1);
        logic first;
        logic done;
        exp_t e;
        first = (mask == 3) ? ~model_last : (mask == 2);
        e.id   = first;
        e.prod = first ? int'(xa1) * int'(xb1) : int'(xa0) * int'(xb0);
        res_q.push_back(e);
        gnt_q.push_back(first);
        if (mask == 3) begin
            e.id   = ~first;
            e.prod = first ? int'(xa0) * int'(xb0) : int'(xa1) * int'(xb1);
            res_q.push_back(e);
            gnt_q.push_back(~first);
            model_last = ~first;
        end else begin
            model_last = first;
        end
        req0 = mask[0]; a0 = xa0; b0 = xb0;
        req1 = mask[1]; a1 = xa1; b1 = xb1;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (req0 && gnt0) begin req0 = 1'b0; a0 = WIDTH'($urandom); b0 = WIDTH'($urandom); end
            if (req1 && gnt1) begin req1 = 1'b0; a1 = WIDTH'($urandom); b1 = WIDTH'($urandom); end
            if (!req0 && !req1 && !busy && res_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            check("round_timeout", 64'd1, 64'd0);
            req0 = 1'b0; req1 = 1'b0;
            res_q.delete(); gnt_q.delete();
        end
    endtask

    task automatic check_outputs_clear(input string tag);
        check({tag, "_gnt0"}, {63'd0, gnt0}, 64'd0);
        check({tag, "_gnt1"}, {63'd0, gnt1}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_p_valid"}, {63'd0, p_valid}, 64'd0);
        check({tag, "_p"}, 64'(p), 64'd0);
        check({tag, "_p_id"}, {63'd0, p_id}, 64'd0);
    endtask

    function automatic logic [WIDTH-1:0] rnd_op();
        return ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
    endfunction

    // Main stimulus sequence.
    initial begin
        logic got;
        // Reset held for two cycles with random inputs.
        for (int i = 0; i < 2; i++) begin
            req0 = 1'($urandom); req1 = 1'($urandom);
            a0 = WIDTH'($urandom); b0 = WIDTH'($urandom);
            a1 = WIDTH'($urandom); b1 = WIDTH'($urandom);
            @(negedge clk);
            check_outputs_clear("reset");
        end
        req0 = 1'b0; req1 = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("idle_busy", {63'd0, busy}, 64'd0);

        // Single request, then simultaneous requests (requester 0 wins first after reset).
        do_round(1, 4'd2, 4'd3, 4'd0, 4'd0);
        model_last = 1'b0;
        do_round(3, 4'd3, 4'd4, 4'd15, 4'd15);

        // Fairness with both requesters held.
        do_round(3, 4'd7, 4'd9, 4'd11, 4'd13);
        do_round(3, 4'd1, 4'd15, 4'd15, 4'd1);

        // Zero operand, operands scrambled after grant.
        do_round(2, 4'd0, 4'd0, 4'd0, 4'd9);

        // Randomized rounds with random idle gaps.
        for (int r = 0; r < 30; r++) begin
            do_round($urandom_range(1, 3), rnd_op(), rnd_op(), rnd_op(), rnd_op());
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Reset in the middle of a run: result discarded, arbitration history cleared.
        gnt_q.push_back(1'b1);
        req1 = 1'b1; a1 = 4'd5; b1 = 4'd5;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (gnt1) got = 1'b1;
        end
        check("mid_run_gnt1_seen", {63'd0, got}, 64'd1);
        req1 = 1'b0; a1 = 4'd3;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_outputs_clear("async_reset");
        gnt_q.delete();
        res_q.delete();
        model_last = 1'b1;
        @(negedge clk);
        check_outputs_clear("held_reset");
        #2 rst = 1'b0;
        @(negedge clk);
        do_round(3, 4'd6, 4'd7, 4'd8, 4'd9);

        repeat (8) @(negedge clk);
        check("res_q_drained", 64'(res_q.size()), 64'd0);
        check("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: the bench must always terminate.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
